// File: rtl/cpu_pkg.sv
// Types and width defaults shared by the pipeline slices and the memory arbiter.
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_I,
    ISSUE_D,
    WAIT_I,
    WAIT_D
  } arb_state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Loadable up-counter timing the wait for a memory response.
// The counter saturates at the expiry point.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count equals the number of enabled cycles already spent, so the
  // TIMEOUT-th enabled cycle is the one that reports expiry.
  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared single-ported memory between fetch and data slices,
// one transaction at a time, and drives the pipeline stall.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W        = CPU_ADDR_W,
  parameter int DATA_W        = CPU_DATA_W,
  parameter int MAX_DM_STREAK = 3,
  parameter int TIMEOUT       = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              stall,
  output logic              protocol_err
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;

  logic dm_elig, if_elig, streak_full, wd_expired;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ISSUE_I || state_q == ISSUE_D),
    .en      (state_q == WAIT_I || state_q == WAIT_D),
    .expired (wd_expired)
  );

  // A requester in its ready cycle is finishing, not asking again.
  assign dm_elig     = dm_req & ~dm_ready_q;
  assign if_elig     = if_req & ~if_flush & ~if_ready_q;
  assign streak_full = (streak_q == STREAK_W'(MAX_DM_STREAK));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    streak_d    = streak_q;
    drop_d      = drop_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (mem_valid) err_d = 1'b1;
        if (dm_elig && !(if_elig && streak_full)) begin
          state_d     = ISSUE_D;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_elig)         streak_d = '0;
          else if (!streak_full) streak_d = streak_q + 1'b1;
        end else if (if_elig) begin
          state_d    = ISSUE_I;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          drop_d     = 1'b0;
          streak_d   = '0;
        end
      end
      ISSUE_I: begin
        if (mem_valid) err_d = 1'b1;
        if (if_flush)  drop_d = 1'b1;
        state_d = WAIT_I;
      end
      ISSUE_D: begin
        if (mem_valid) err_d = 1'b1;
        state_d = WAIT_D;
      end
      WAIT_I: begin
        if (mem_valid) begin
          // A flush arriving with the response still cancels it.
          if_rdata_d = mem_rdata;
          if_ready_d = ~(drop_q | if_flush);
          state_d    = IDLE;
        end else begin
          if (if_flush) drop_d = 1'b1;
          if (wd_expired) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_D: begin
        if (mem_valid) begin
          dm_rdata_d = mem_rdata;
          dm_ready_d = 1'b1;
          state_d    = IDLE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      drop_q      <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      drop_q      <= drop_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata     = if_rdata_q;
  assign if_ready     = if_ready_q;
  assign dm_rdata     = dm_rdata_q;
  assign dm_ready     = dm_ready_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign protocol_err = err_q;
  assign stall        = (if_req & ~if_ready_q & ~if_flush) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory model plus
// per-port scoreboards of expected read data.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_ready;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_ready;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;
  logic          stall, protocol_err;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .stall(stall), .protocol_err(protocol_err)
  );

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] dm_q[$];

  // Memory model: answers each issue `lat` cycles later with addr ^ A5B5.
  int            lat   = 1;
  bit            mute  = 1'b0;
  bit            stray = 1'b0;
  int            cd    = 0;
  logic [AW-1:0] pend  = '0;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return a ^ 16'hA5B5;
  endfunction

  always @(posedge clk) begin
    #1;
    mem_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mem_valid = 1'b1;
        mem_rdata = mem_model(pend);
      end
    end
    if (mem_en && !mute) begin
      cd   = lat;
      pend = mem_addr;
    end
    if (stray) begin
      mem_valid = 1'b1;
      mem_rdata = 16'hDEAD;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any completion pulse.
  task automatic tick();
    @(negedge clk);
    if (if_ready) begin
      if (if_q.size() == 0) check("if_ready_unexpected", 32'(if_ready), 32'd0);
      else                  check("if_rdata", 32'(if_rdata), 32'(if_q.pop_front()));
    end
    if (dm_ready) begin
      if (dm_q.size() == 0) check("dm_ready_unexpected", 32'(dm_ready), 32'd0);
      else                  check("dm_rdata", 32'(dm_rdata), 32'(dm_q.pop_front()));
    end
  endtask

  task automatic wait_dm(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dm_ready && n < budget);
    check("dm_ready_seen", 32'(dm_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL tb_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            n;
    int            dcount;
    bit            fetch_done;
    bit            grants[$];
    logic [4:0]    order;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick(); tick();
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_dm_ready", 32'(dm_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_if_rdata", 32'(if_rdata), 32'd0);
    check("rst_err", 32'(protocol_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single fetch, L = 2.
    lat = 2; if_req = 1'b1; if_addr = 16'h0010; if_q.push_back(16'hA5A5);
    #1 check("f_stall_c0", 32'(stall), 32'd1);
    tick();
    check("f_mem_en_c1", 32'(mem_en), 32'd1);
    check("f_mem_addr", 32'(mem_addr), 32'h0010);
    check("f_mem_we", 32'(mem_we), 32'd0);
    tick();
    check("f_mem_en_c2", 32'(mem_en), 32'd0);
    tick();
    check("f_stall_c3", 32'(stall), 32'd1);
    check("f_ready_c3", 32'(if_ready), 32'd0);
    tick();
    check("f_ready_c4", 32'(if_ready), 32'd1);
    check("f_stall_c4", 32'(stall), 32'd0);
    if_req = 1'b0;

    // Contention, L = 1: data first, fetch issued right after dm_ready.
    tick();
    lat = 1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200; dm_q.push_back(mem_model(16'h0200));
    if_req = 1'b1; if_addr = 16'h0300; if_q.push_back(mem_model(16'h0300));
    tick();
    check("c_first_addr", 32'(mem_addr), 32'h0200);
    check("c_first_en", 32'(mem_en), 32'd1);
    tick(); tick();
    check("c_dm_ready", 32'(dm_ready), 32'd1);
    check("c_no_en_ready", 32'(mem_en), 32'd0);
    dm_req = 1'b0;
    tick();
    check("c_fetch_en", 32'(mem_en), 32'd1);
    check("c_fetch_addr", 32'(mem_addr), 32'h0300);
    tick(); tick();
    check("c_if_ready", 32'(if_ready), 32'd1);
    if_req = 1'b0;

    // Data write, L = 3.
    tick();
    lat = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0400; dm_wdata = 16'hBEEF;
    dm_q.push_back(mem_model(16'h0400));
    tick();
    check("w_mem_en", 32'(mem_en), 32'd1);
    check("w_mem_we", 32'(mem_we), 32'd1);
    check("w_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    wait_dm(20, n);
    check("w_latency", 32'(n), 32'd4);
    dm_req = 1'b0; dm_we = 1'b0;

    // Streak limit: fetch withdraws during each data-ready cycle, so only
    // the streak limit can let it past a steady stream of data requests.
    tick();
    lat = 1;
    dm_req = 1'b1; dm_addr = 16'h0500; dm_q.push_back(mem_model(16'h0500));
    if_req = 1'b1; if_addr = 16'h0600; if_q.push_back(mem_model(16'h0600));
    dcount = 0; fetch_done = 1'b0;
    for (int c = 0; c < 80 && !(dcount == 4 && fetch_done); c++) begin
      tick();
      if (mem_en) grants.push_back(mem_addr == 16'h0600);
      if (dm_ready) begin
        dcount++;
        if (dcount < 4) begin
          dm_addr = 16'h0500 + 16'(dcount * 16);
          dm_q.push_back(mem_model(dm_addr));
        end else begin
          dm_req = 1'b0;
        end
      end
      if (if_ready) fetch_done = 1'b1;
      if_req = !fetch_done && !dm_ready;
    end
    if_req = 1'b0;
    check("s_done", 32'({dcount == 4, fetch_done}), 32'b11);
    check("s_grants", 32'(grants.size()), 32'd5);
    order = '0;
    for (int i = 0; i < 5 && i < grants.size(); i++) order[4-i] = grants[i];
    check("s_order", 32'(order), 32'b00010);

    // Flush during WAIT_I, L = 5; data request waits behind it.
    tick();
    lat = 5; if_req = 1'b1; if_addr = 16'h0700;
    tick();
    check("fl_mem_addr", 32'(mem_addr), 32'h0700);
    tick(); tick();
    if_flush = 1'b1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0800; dm_q.push_back(mem_model(16'h0800));
    #1 check("fl_stall", 32'(stall), 32'd1);
    tick();
    if_flush = 1'b0; if_req = 1'b0;
    tick(); tick(); tick();
    check("fl_no_ready", 32'(if_ready), 32'd0);
    check("fl_no_en", 32'(mem_en), 32'd0);
    tick();
    check("fl_dm_en", 32'(mem_en), 32'd1);
    check("fl_dm_addr", 32'(mem_addr), 32'h0800);
    wait_dm(10, n);
    dm_req = 1'b0;

    // Flush in the very cycle the fetch response arrives, L = 2.
    tick();
    lat = 2; if_req = 1'b1; if_addr = 16'h0900;
    tick(); tick(); tick();
    if_flush = 1'b1;
    #1 check("fv_stall", 32'(stall), 32'd0);
    tick();
    check("fv_no_ready", 32'(if_ready), 32'd0);
    if_flush = 1'b0; if_req = 1'b0;
    tick();
    check("fv_idle", 32'(mem_en), 32'd0);

    // Timeout: no response, then a stray late response.
    tick();
    mute = 1'b1; if_req = 1'b1; if_addr = 16'h0A00;
    tick();
    check("t_mem_en", 32'(mem_en), 32'd1);
    repeat (TO) tick();
    check("t_err_before", 32'(protocol_err), 32'd0);
    tick();
    check("t_err_set", 32'(protocol_err), 32'd1);
    check("t_no_ready", 32'(if_ready), 32'd0);
    if_req = 1'b0;
    tick();
    check("t_idle", 32'(mem_en), 32'd0);
    mute = 1'b0; stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    check("t_stray_no_ready", 32'(if_ready | dm_ready), 32'd0);
    check("t_err_sticky", 32'(protocol_err), 32'd1);
    lat = 1; dm_req = 1'b1; dm_addr = 16'h0B00; dm_q.push_back(mem_model(16'h0B00));
    wait_dm(10, n);
    dm_req = 1'b0;
    check("t_err_still", 32'(protocol_err), 32'd1);

    // Reset clears the error; a transaction abandoned by reset answers late.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_err_clear", 32'(protocol_err), 32'd0);
    lat = 3; if_req = 1'b1; if_addr = 16'h0C00;
    tick();
    check("r_mem_en", 32'(mem_en), 32'd1);
    tick();
    rst = 1'b1; if_req = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    check("r_no_ready", 32'(if_ready), 32'd0);
    check("r_late_err", 32'(protocol_err), 32'd1);
    check("r_queues_empty", 32'(if_q.size() + dm_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
